// File: rtl/alu_pkg.sv
// Shared types and constants for the sequenced ALU control unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MULT = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_SL   = 4'd4,
    ALU_SR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_NOR  = 4'd9,
    ALU_JR   = 4'd10,
    ALU_NAND = 4'd11,
    ALU_NOT  = 4'd12,
    ALU_SLT  = 4'd13,
    ALU_SGT  = 4'd14
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b11;

  // Function-field window that maps linearly onto alu_ctrl_t.
  localparam logic [4:0] OP_BASE = 5'b01000;
  localparam logic [4:0] OP_LAST = 5'b10110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_seq_dec.sv
// Combinational decode of {aluop, op} into control code, illegal flag and
// multi-cycle class.
module alu_dec_comb
  import alu_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        aluop,
  input  logic [OP_W-1:0]   op,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              is_mult,
  output logic              is_div
);

  localparam logic [OP_W-1:0] BASE = OP_W'(OP_BASE);
  localparam logic [OP_W-1:0] LAST = OP_W'(OP_LAST);

  logic [OP_W-1:0] op_off;
  logic            in_range;

  assign op_off   = op - BASE;
  assign in_range = (op >= BASE) && (op <= LAST);

  // aluop forces ADD/SUB; otherwise the function field selects the code.
  always_comb begin
    alucontrol = '0;
    illegal    = 1'b0;
    is_mult    = 1'b0;
    is_div     = 1'b0;
    if (aluop == ALUOP_ADD) begin
      alucontrol = CTRL_W'(ALU_ADD);
    end else if (aluop == ALUOP_SUB) begin
      alucontrol = CTRL_W'(ALU_SUB);
    end else if (in_range) begin
      alucontrol = CTRL_W'(op_off);
      is_mult    = (op_off == OP_W'(ALU_MULT));
      is_div     = (op_off == OP_W'(ALU_DIV));
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control: decode, latency tracking and valid/ready handshakes.
//
// state | meaning
// IDLE  | no result held, ready for a new op
// BUSY  | multi-cycle op counting down in cnt_q
// DONE  | result presented, held until out_ready
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [OP_W-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               ill_q, ill_d;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_ill, dec_mult, dec_div;
  logic               accept;

  alu_dec_comb #(
    .OP_W   (OP_W),
    .CTRL_W (CTRL_W)
  ) u_dec (
    .aluop      (aluop),
    .op         (op),
    .alucontrol (dec_ctrl),
    .illegal    (dec_ill),
    .is_mult    (dec_mult),
    .is_div     (dec_div)
  );

  // Ready when empty, or when the held result leaves this cycle; never during flush.
  assign in_ready   = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == BUSY);
  assign alucontrol = ctrl_q;
  assign illegal    = ill_q;

  // Next-state: accept/load, countdown, drain, with flush overriding all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    case (state_q)
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ctrl_d = dec_ctrl;
      ill_d  = dec_ill;
      if (dec_mult && (MUL_LAT > 1)) begin
        state_d = BUSY;
        cnt_d   = MUL_CNT;
      end else if (dec_div && (DIV_LAT > 1)) begin
        state_d = BUSY;
        cnt_d   = DIV_CNT;
      end else begin
        state_d = DONE;
        cnt_d   = '0;
      end
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State registers; synchronous reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq against a transaction-level model.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [1:0] aluop;
  logic [4:0] op;
  logic       in_ready, out_valid, illegal, busy;
  logic [3:0] alucontrol;

  alu_ctrl_seq #(
    .OP_W    (5),
    .CTRL_W  (4),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluop      (aluop),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: one outstanding op, ready at a known cycle number.
  bit have;
  int ready_cyc;
  int cyc;
  int e_ctrl;
  bit e_ill;
  bit known;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_dec(input logic [1:0] a, input logic [4:0] o,
                                    output int c, output bit ill, output int lat);
    int ov;
    ov  = int'(o);
    ill = 1'b0;
    c   = 0;
    if (a == 2'b00)      c = 0;
    else if (a == 2'b11) c = 1;
    else if (ov >= 8 && ov <= 22) c = ov - 8;
    else ill = 1'b1;
    if (a != 2'b00 && a != 2'b11 && !ill && c == 2)      lat = MUL_LAT;
    else if (a != 2'b00 && a != 2'b11 && !ill && c == 3) lat = DIV_LAT;
    else lat = 1;
  endfunction

  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [1:0] a, input logic [4:0] o, input bit ordy);
    bit ev, eb, eir;
    int c, lat;
    bit ill;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; aluop = a; op = o; out_ready = ordy;
    #1;
    ev  = have && (cyc >= ready_cyc);
    eb  = have && (cyc < ready_cyc);
    eir = !fl && (!have || (ev && ordy));
    chk("out_valid", int'(out_valid), int'(ev));
    chk("busy", int'(busy), int'(eb));
    if (!rst) chk("in_ready", int'(in_ready), int'(eir));
    if (ev || (known && !have)) begin
      chk("alucontrol", int'(alucontrol), e_ctrl);
      chk("illegal", int'(illegal), int'(e_ill));
    end
    if (rst) begin
      have = 0; known = 1; e_ctrl = 0; e_ill = 0;
    end else if (fl) begin
      have = 0;
    end else begin
      if (ev && ordy) have = 0;
      if (iv && eir) begin
        model_dec(a, o, c, ill, lat);
        have = 1; known = 0;
        e_ctrl = c; e_ill = ill;
        ready_cyc = cyc + lat;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 5'd0, ordy);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; aluop = 0; op = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    have = 0; known = 1; e_ctrl = 0; e_ill = 0; cyc = 0; ready_cyc = 0;
    step(1, 0, 0, 2'b00, 5'd0, 0);
    idle(1, 1);

    // single-cycle AND via function field
    step(0, 0, 1, 2'b10, 5'b01110, 1);
    idle(2, 1);
    // mult latency
    step(0, 0, 1, 2'b01, 5'b01010, 1);
    idle(5, 1);
    // back-to-back stream, then backpressure
    step(0, 0, 1, 2'b10, 5'b01000, 1);
    step(0, 0, 1, 2'b10, 5'b01001, 1);
    step(0, 0, 1, 2'b10, 5'b01111, 1);
    step(0, 0, 1, 2'b10, 5'b01000, 0);
    idle(2, 0);
    idle(2, 1);
    // illegal op and forced SUB
    step(0, 0, 1, 2'b01, 5'b11111, 1);
    idle(1, 1);
    step(0, 0, 1, 2'b11, 5'b00101, 1);
    idle(1, 1);
    // div aborted by flush, then by reset
    step(0, 0, 1, 2'b10, 5'b01011, 1);
    idle(4, 1);
    step(0, 1, 1, 2'b10, 5'b01000, 1);
    idle(18, 1);
    step(0, 0, 1, 2'b10, 5'b01011, 1);
    idle(4, 1);
    step(1, 0, 1, 2'b10, 5'b01000, 1);
    idle(18, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, f, v, rd;
      logic [1:0] a;
      logic [4:0] o;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 7);
      a  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) o = 5'($urandom_range(8, 22));
      else                            o = 5'($urandom_range(0, 31));
      step(r, f, v, a, o, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
